// File: rtl/serial_adder_seq_pkg.sv
// serial_adder_seq_pkg: shared FSM encoding, default width and counter sizing helper
package serial_adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter needs at least one bit even when WIDTH is 1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/adder_test.sv
// adder_test: 1-bit half adder stage
//   i_bit1, i_bit2 : operand bits
//   o_sum          : i_bit1 ^ i_bit2
//   o_carry        : i_bit1 & i_bit2
module adder_test (
    input  logic i_bit1,
    input  logic i_bit2,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_bit1 ^ i_bit2;
    assign o_carry = i_bit1 & i_bit2;

endmodule

// File: rtl/serial_add_top.sv
// serial_add_top: serial adder controller wired to its half adder stage
//   clk, i_rst_n     : clock, synchronous active-low reset
//   i_valid/o_ready  : operand handshake, i_op_a/i_op_b operands
//   o_valid/i_ready  : result handshake, o_result/o_carry_out result
module serial_add_top
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out
);

    logic bit1, bit2, sum, carry;

    serial_adder_seq #(.WIDTH(WIDTH)) u_seq (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .o_bit1     (bit1),
        .o_bit2     (bit2),
        .i_sum      (sum),
        .i_carry    (carry),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_carry_out(o_carry_out)
    );

    adder_test u_ha (
        .i_bit1 (bit1),
        .i_bit2 (bit2),
        .o_sum  (sum),
        .o_carry(carry)
    );

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder controller driving an external half adder
//   clk, i_rst_n            : clock, synchronous active-low reset
//   i_valid/o_ready         : operand handshake, i_op_a/i_op_b operands
//   o_bit1/o_bit2           : LSB-first operand bits to the half adder (RUN only)
//   i_sum/i_carry           : half adder returns, sampled in RUN
//   o_valid/i_ready         : result handshake, o_result/o_carry_out result
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_bit1,
    output logic             o_bit2,
    input  logic             i_sum,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             s;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        // Half-adder sum folded with our carry gives the full-adder sum bit.
        s        = i_sum ^ carry_q;
        case (state_q)
            IDLE: if (i_valid) begin
                a_sh_d  = i_op_a;
                b_sh_d  = i_op_b;
                cnt_d   = '0;
                carry_d = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                carry_d  = i_carry | (i_sum & carry_q);
                // Shift s in at the MSB; written this way so WIDTH=1 needs no empty slice.
                res_sh_d = WIDTH'({s, res_sh_q} >> 1);
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == LAST) ? DONE : RUN;
            end
            DONE: state_d = i_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_bit1      = (state_q == RUN) & a_sh_q[0];
    assign o_bit2      = (state_q == RUN) & b_sh_q[0];
    assign o_result    = o_valid ? res_sh_q : '0;
    assign o_carry_out = o_valid & carry_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed and random scoreboard bench for the serial adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0, rdy = 1'b1;
    logic [7:0] op_a = '0, op_b = '0;
    logic       o_ready, o_valid, o_bit1, o_bit2, o_carry_out, ha_sum, ha_carry;
    logic [7:0] o_result;

    logic       v1 = 1'b0, rdy1 = 1'b1, a1 = 1'b0, b1 = 1'b0;
    logic       ready1, valid1, res1, co1;

    int         checks = 0, passed = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .o_ready    (o_ready),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .o_bit1     (o_bit1),
        .o_bit2     (o_bit2),
        .i_sum      (ha_sum),
        .i_carry    (ha_carry),
        .o_valid    (o_valid),
        .i_ready    (rdy),
        .o_result   (o_result),
        .o_carry_out(o_carry_out)
    );

    adder_test u_ha (
        .i_bit1 (o_bit1),
        .i_bit2 (o_bit2),
        .o_sum  (ha_sum),
        .o_carry(ha_carry)
    );

    serial_add_top #(.WIDTH(1)) u_top1 (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_valid    (v1),
        .o_ready    (ready1),
        .i_op_a     (a1),
        .i_op_b     (b1),
        .o_valid    (valid1),
        .i_ready    (rdy1),
        .o_result   (res1),
        .o_carry_out(co1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_add(input logic [7:0] a, input logic [7:0] b);
        int n;
        op_a = a;
        op_b = b;
        valid = 1'b1;
        rdy = 1'b1;
        sb.push_back(9'(a) + 9'(b));
        tick();
        valid = 1'b0;
        chk("run_ready", 33'(o_ready), 33'(0));
        chk("bit1", 33'(o_bit1), 33'(a[0]));
        chk("bit2", 33'(o_bit2), 33'(b[0]));
        n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 33'(n), 33'(8));
        chk("result", 33'({o_carry_out, o_result}), 33'(sb.pop_front()));
        tick();
        chk("valid_pulse", 33'(o_valid), 33'(0));
        chk("ready_back", 33'(o_ready), 33'(1));
    endtask

    task automatic do_add1(input logic a, input logic b);
        int n;
        a1 = a;
        b1 = b;
        v1 = 1'b1;
        sb.push_back(9'(a) + 9'(b));
        tick();
        v1 = 1'b0;
        n = 0;
        while (!valid1 && n < 10) begin
            tick();
            n++;
        end
        chk("w1_latency", 33'(n), 33'(1));
        chk("w1_result", 33'({co1, res1}), 33'(sb.pop_front()));
        tick();
        chk("w1_ready", 33'(ready1), 33'(1));
    endtask

    initial begin
        int n, acc, cyc;
        logic [8:0] e;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready", 33'(o_ready), 33'(1));
        chk("rst_valid", 33'(o_valid), 33'(0));
        chk("rst_result", 33'({o_carry_out, o_result}), 33'(0));
        chk("rst_bits", 33'({o_bit1, o_bit2}), 33'(0));
        rst_n = 1'b1;
        tick();
        do_add(8'h05, 8'h03);
        do_add(8'hFF, 8'h01);
        do_add(8'hFF, 8'hFF);
        do_add(8'h00, 8'h00);
        // Backpressure with a competing operand held valid.
        op_a = 8'h05;
        op_b = 8'h03;
        valid = 1'b1;
        rdy = 1'b0;
        sb.push_back(9'h008);
        tick();
        valid = 1'b0;
        n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_latency", 33'(n), 33'(8));
        op_a = 8'h10;
        op_b = 8'h22;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_result", 33'(o_result), 33'(8'h08));
            chk("bp_ready", 33'(o_ready), 33'(0));
            chk("bp_valid", 33'(o_valid), 33'(1));
        end
        chk("bp_final", 33'({o_carry_out, o_result}), 33'(sb.pop_front()));
        rdy = 1'b1;
        tick();
        chk("bp_released", 33'({o_valid, o_ready}), 33'(2'b01));
        sb.push_back(9'h032);
        tick();
        valid = 1'b0;
        n = 0;
        while (!o_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_next_latency", 33'(n), 33'(8));
        chk("bp_next", 33'({o_carry_out, o_result}), 33'(sb.pop_front()));
        tick();
        // Reset on the 4th RUN cycle aborts the add.
        op_a = 8'h55;
        op_b = 8'h11;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_ready", 33'(o_ready), 33'(1));
        chk("abort_valid", 33'(o_valid), 33'(0));
        chk("abort_result", 33'(o_result), 33'(0));
        do_add(8'h7F, 8'h01);
        // WIDTH=1 build, all four input pairs.
        do_add1(1'b0, 1'b0);
        do_add1(1'b1, 1'b0);
        do_add1(1'b0, 1'b1);
        do_add1(1'b1, 1'b1);
        // Random traffic with random valid/ready gaps.
        acc = 0;
        cyc = 0;
        while ((acc < 1000 || sb.size() != 0) && cyc < 60000) begin
            valid = (acc < 1000) && ($urandom_range(0, 1) == 1);
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            rdy = ($urandom_range(0, 1) == 1);
            if (o_valid && rdy) begin
                if (sb.size() == 0) chk("rand_dup", 33'(1), 33'(0));
                else begin
                    e = sb.pop_front();
                    chk("rand_result", 33'({o_carry_out, o_result}), 33'(e));
                end
            end
            if (valid && o_ready) begin
                sb.push_back(9'(op_a) + 9'(op_b));
                acc++;
            end
            tick();
            cyc++;
        end
        valid = 1'b0;
        chk("rand_accepted", 33'(acc), 33'(1000));
        chk("rand_drained", 33'(sb.size()), 33'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
